// File: rtl/sisc_fetch.sv
// SISC fetch stage: PC, imem req/ack handshake, IR, branch redirect and halt.
// IR valid one cycle after imem_ack; no new fetch until ir_ack retires the IR.
module sisc_fetch #(
  parameter int                     PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_f,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic [31:0]         instruction,
  output logic                ir_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  input  logic                ir_ack,
  input  logic                pc_sel,
  input  logic                br_rel,
  input  logic [PC_WIDTH-1:0] br_addr,
  input  logic                halt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    FULL   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]         ir_q, ir_d;
  logic                ir_valid_q, ir_valid_d;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_out_d   = pc_q;
          pc_d       = pc_q + PC_WIDTH'(1);
          ir_valid_d = 1'b1;
          state_d    = FULL;
        end
      end
      FULL: begin
        // pc_q already points past the IR word, so relative targets are pc_out+1+offset
        if (ir_ack && ir_valid_q) begin
          ir_valid_d = 1'b0;
          if (halt) begin
            state_d = HALTED;
          end else begin
            state_d = FETCH;
            if (pc_sel) begin
              pc_d = br_rel ? (pc_q + br_addr) : br_addr;
            end
          end
        end
      end
      HALTED: ir_valid_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instruction = ir_q;
  assign ir_valid    = ir_valid_q;
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: stepped vector table plus halt-hold and async-reset sequences.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instruction;
  logic        ir_valid;
  logic [15:0] pc_out;
  logic        ir_ack, pc_sel, br_rel, halt;
  logic [15:0] br_addr;

  int total = 0;
  int bad   = 0;

  sisc_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_f(rst_f),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instruction(instruction), .ir_valid(ir_valid), .pc_out(pc_out),
    .ir_ack(ir_ack), .pc_sel(pc_sel), .br_rel(br_rel),
    .br_addr(br_addr), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rd;
    logic        ia, ps, br;
    logic [15:0] ba;
    logic        h;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [15:0] e_pc;
  } vec_t;

  vec_t tv[30];

  function automatic vec_t v(input logic e_req, input logic [15:0] e_addr, input logic e_vld,
                             input logic [31:0] e_ins, input logic [15:0] e_pc,
                             input logic ack, input logic [31:0] rd, input logic ia,
                             input logic ps, input logic br, input logic [15:0] ba,
                             input logic h);
    vec_t r;
    r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld; r.e_ins = e_ins; r.e_pc = e_pc;
    r.ack = ack; r.rd = rd; r.ia = ia; r.ps = ps; r.br = br; r.ba = ba; r.h = h;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [15:0] ea,
                         input logic ev, input logic [31:0] ei, input logic [15:0] ep);
    chk({tag, ".imem_req"},    {31'd0, imem_req}, {31'd0, er});
    chk({tag, ".imem_addr"},   {16'd0, imem_addr}, {16'd0, ea});
    chk({tag, ".ir_valid"},    {31'd0, ir_valid}, {31'd0, ev});
    chk({tag, ".instruction"}, instruction, ei);
    chk({tag, ".pc_out"},      {16'd0, pc_out}, {16'd0, ep});
  endtask

  task automatic drive(input logic ack, input logic [31:0] rd, input logic ia, input logic ps,
                       input logic br, input logic [15:0] ba, input logic h);
    imem_ack = ack; imem_rdata = rd; ir_ack = ia; pc_sel = ps; br_rel = br; br_addr = ba; halt = h;
  endtask

  initial begin
    //          exp: req addr     vld ins           pc        in: ack rdata        ia ps br ba       h
    tv[0]  = v(0, 16'h0000, 0, 32'h00000000, 16'h0000, 0, 32'h0,        0, 0, 0, 16'h0000, 0);
    tv[1]  = v(1, 16'h0000, 0, 32'h00000000, 16'h0000, 1, 32'h10000000, 0, 0, 0, 16'h0000, 0);
    tv[2]  = v(0, 16'h0001, 1, 32'h10000000, 16'h0000, 0, 32'h0,        1, 0, 0, 16'h0000, 0);
    tv[3]  = v(1, 16'h0001, 0, 32'h10000000, 16'h0000, 1, 32'h20000001, 0, 0, 0, 16'h0000, 0);
    tv[4]  = v(0, 16'h0002, 1, 32'h20000001, 16'h0001, 0, 32'h0,        1, 0, 0, 16'h0000, 0);
    tv[5]  = v(1, 16'h0002, 0, 32'h20000001, 16'h0001, 1, 32'h30000002, 0, 0, 0, 16'h0000, 0);
    tv[6]  = v(0, 16'h0003, 1, 32'h30000002, 16'h0002, 0, 32'h0,        1, 0, 0, 16'h0000, 0);
    // wait states: redirect/halt during FETCH must be ignored
    tv[7]  = v(1, 16'h0003, 0, 32'h30000002, 16'h0002, 0, 32'h0,        1, 1, 0, 16'h0077, 1);
    tv[8]  = v(1, 16'h0003, 0, 32'h30000002, 16'h0002, 0, 32'h0,        0, 0, 0, 16'h0000, 0);
    tv[9]  = v(1, 16'h0003, 0, 32'h30000002, 16'h0002, 0, 32'h0,        0, 0, 0, 16'h0000, 0);
    tv[10] = v(1, 16'h0003, 0, 32'h30000002, 16'h0002, 1, 32'h40000003, 0, 0, 0, 16'h0000, 0);
    // backpressure: stray ack in FULL ignored, IR held until ir_ack
    tv[11] = v(0, 16'h0004, 1, 32'h40000003, 16'h0003, 1, 32'hDEADBEEF, 0, 0, 0, 16'h0000, 0);
    tv[12] = v(0, 16'h0004, 1, 32'h40000003, 16'h0003, 0, 32'h0,        0, 0, 0, 16'h0000, 0);
    tv[13] = v(0, 16'h0004, 1, 32'h40000003, 16'h0003, 0, 32'h0,        0, 0, 0, 16'h0000, 0);
    tv[14] = v(0, 16'h0004, 1, 32'h40000003, 16'h0003, 0, 32'h0,        1, 0, 0, 16'h0000, 0);
    tv[15] = v(1, 16'h0004, 0, 32'h40000003, 16'h0003, 1, 32'h50000004, 0, 0, 0, 16'h0000, 0);
    tv[16] = v(0, 16'h0005, 1, 32'h50000004, 16'h0004, 0, 32'h0,        1, 0, 0, 16'h0000, 0);
    tv[17] = v(1, 16'h0005, 0, 32'h50000004, 16'h0004, 1, 32'h60000005, 0, 0, 0, 16'h0000, 0);
    tv[18] = v(0, 16'h0006, 1, 32'h60000005, 16'h0005, 0, 32'h0,        1, 1, 0, 16'h0040, 0);
    tv[19] = v(1, 16'h0040, 0, 32'h60000005, 16'h0005, 1, 32'h70000040, 0, 0, 0, 16'h0000, 0);
    tv[20] = v(0, 16'h0041, 1, 32'h70000040, 16'h0040, 0, 32'h0,        1, 1, 0, 16'h0008, 0);
    tv[21] = v(1, 16'h0008, 0, 32'h70000040, 16'h0040, 1, 32'h80000008, 0, 0, 0, 16'h0000, 0);
    tv[22] = v(0, 16'h0009, 1, 32'h80000008, 16'h0008, 0, 32'h0,        1, 1, 1, 16'hFFFC, 0);
    tv[23] = v(1, 16'h0005, 0, 32'h80000008, 16'h0008, 1, 32'h90000005, 0, 0, 0, 16'h0000, 0);
    tv[24] = v(0, 16'h0006, 1, 32'h90000005, 16'h0005, 0, 32'h0,        1, 1, 0, 16'hFFFF, 0);
    tv[25] = v(1, 16'hFFFF, 0, 32'h90000005, 16'h0005, 1, 32'hA000FFFF, 0, 0, 0, 16'h0000, 0);
    tv[26] = v(0, 16'h0000, 1, 32'hA000FFFF, 16'hFFFF, 0, 32'h0,        1, 0, 0, 16'h0000, 0);
    tv[27] = v(1, 16'h0000, 0, 32'hA000FFFF, 16'hFFFF, 1, 32'hB0000000, 0, 0, 0, 16'h0000, 0);
    tv[28] = v(0, 16'h0001, 1, 32'hB0000000, 16'h0000, 0, 32'h0,        1, 1, 0, 16'h1234, 1);
    tv[29] = v(0, 16'h0001, 0, 32'hB0000000, 16'h0000, 0, 32'h0,        0, 0, 0, 16'h0000, 0);

    rst_f = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 16'h0, 0);
    #2;
    chk_all("reset", 0, 16'h0000, 0, 32'h0, 16'h0000);

    @(negedge clk);
    rst_f = 1'b1;
    for (int i = 0; i < 30; i++) begin
      chk_all($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_vld, tv[i].e_ins, tv[i].e_pc);
      drive(tv[i].ack, tv[i].rd, tv[i].ia, tv[i].ps, tv[i].br, tv[i].ba, tv[i].h);
      @(posedge clk);
      #1;
    end

    // HALTED must stay put whatever the inputs do
    for (int i = 0; i < 20; i++) begin
      drive(i[0], 32'hFFFF0000, 1, 1, i[1], 16'h0100, i[2]);
      @(posedge clk);
      #1;
      chk($sformatf("halted%0d.imem_req", i), {31'd0, imem_req}, 32'd0);
      chk($sformatf("halted%0d.imem_addr", i), {16'd0, imem_addr}, 32'h0001);
    end
    chk("halted.instruction", instruction, 32'hB0000000);
    chk("halted.ir_valid", {31'd0, ir_valid}, 32'd0);

    // restart, fetch one word, then reset asynchronously in the middle of a wait
    drive(0, 32'h0, 0, 0, 0, 16'h0, 0);
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst2_fetch", 1, 16'h0000, 0, 32'h0, 16'h0000);
    drive(1, 32'hC0000000, 0, 0, 0, 16'h0, 0);
    @(posedge clk);
    #1;
    chk_all("rst2_full", 0, 16'h0001, 1, 32'hC0000000, 16'h0000);
    drive(0, 32'h0, 1, 0, 0, 16'h0, 0);
    @(posedge clk);
    #1;
    drive(0, 32'h0, 0, 0, 0, 16'h0, 0);
    chk_all("prewait", 1, 16'h0001, 0, 32'hC0000000, 16'h0000);
    #2;
    rst_f = 1'b0;
    #1;
    chk_all("async_rst", 0, 16'h0000, 0, 32'h0, 16'h0000);
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    chk("post_rst_idle.imem_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk_all("post_rst_fetch", 1, 16'h0000, 0, 32'h0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
